// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: time-shares one combinational ALU among N_REQ valid/ready requesters.
// Define ALU_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (lowest index wins).
module alu_share_arbiter #(
  parameter int N_REQ  = 2,
  parameter int DATA_W = 17
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [2*N_REQ-1:0]      req_op,
  input  logic [DATA_W*N_REQ-1:0] req_a,
  input  logic [DATA_W*N_REQ-1:0] req_b,
  output logic [N_REQ-1:0]        rsp_valid,
  input  logic [N_REQ-1:0]        rsp_ready,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_zero,
  output logic                    rsp_sign,
  output logic                    rsp_ovf,
  output logic [1:0]              alu_ctrl,
  output logic [DATA_W-1:0]       alu_a,
  output logic [DATA_W-1:0]       alu_b,
  input  logic [DATA_W-1:0]       alu_out,
  input  logic                    alu_zero,
  input  logic                    alu_sign,
  input  logic                    alu_ovf,
  output logic                    busy
);

  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_t;

  state_t            state;
  logic [1:0]        op_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [OW-1:0]     owner;
  logic [OW-1:0]     winner;
  logic              found;
  logic [N_REQ-1:0]  winner_onehot;
  logic [N_REQ-1:0]  owner_onehot;

`ifdef ALU_ARB_RR_EN
  logic [OW-1:0] rr_ptr;

  // Search starts at the pointer and wraps, so the last winner drops to lowest priority.
  always_comb begin
    int idx;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = OW'(idx);
      end
    end
  end
`else
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        found  = 1'b1;
        winner = OW'(k);
      end
    end
  end
`endif

  assign winner_onehot = N_REQ'(1) << winner;
  assign owner_onehot  = N_REQ'(1) << owner;

  // Grants are offered only while idle and out of reset, so req_ready is never more than one-hot.
  assign req_ready = (rst_n && state == IDLE && found) ? winner_onehot : '0;

  assign alu_ctrl = op_q;
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      owner     <= '0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
      rsp_sign  <= 1'b0;
      rsp_ovf   <= 1'b0;
      rsp_valid <= '0;
`ifdef ALU_ARB_RR_EN
      rr_ptr    <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op_q  <= req_op[winner*2 +: 2];
            a_q   <= req_a[winner*DATA_W +: DATA_W];
            b_q   <= req_b[winner*DATA_W +: DATA_W];
            owner <= winner;
            state <= EXEC;
`ifdef ALU_ARB_RR_EN
            rr_ptr <= (int'(winner) == N_REQ - 1) ? '0 : winner + 1'b1;
`endif
          end
        end
        EXEC: begin
          // Logic ops cannot overflow, so the flag is masked whatever the ALU reports.
          rsp_data  <= alu_out;
          rsp_zero  <= alu_zero;
          rsp_sign  <= alu_sign;
          rsp_ovf   <= alu_ovf & ~op_q[1];
          rsp_valid <= owner_onehot;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready[owner]) begin
            rsp_valid <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          rsp_valid <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
